uart_cmd_rx: RTL

UART receiver that mirrors the core's UART transmitter: 8N1, LSB first, idle-high line. Assembles two received bytes into a manual-mode command (operand A, operand B, opcode, mode bit). Presents the command through a valid/ready handshake to the top-level operand/opcode selection logic. Also exposes raw bytes and error pulses for debug and bring-up.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_byte.sv | 164 ++++++++++++++++
 rtl/uart_cmd_rx.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared state encoding, command signature and byte-field positions for the UART command receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rxState_t;

   localparam logic [3:0] CMD_SIGNATURE = 4'hA;
   localparam int BIT_IDX_W = 3;

   // Byte 0 carries the operands, byte 1 the opcode, mode and signature.
   localparam int A_MSB    = 7;
   localparam int A_LSB    = 4;
   localparam int B_MSB    = 3;
   localparam int B_LSB    = 0;
   localparam int OPC_MSB  = 7;
   localparam int OPC_LSB  = 5;
   localparam int MODE_POS = 4;
   localparam int SIG_MSB  = 3;
   localparam int SIG_LSB  = 0;

   function automatic logic sigOk(input logic [7:0] b);
      return b[SIG_MSB:SIG_LSB] == CMD_SIGNATURE;
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Two-flop rx synchroniser plus byte-framing FSM (8N1, or 8E1 when UART_RX_PARITY_EN is defined).
module uart_rx_byte
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 87
)
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_ena,
   input  logic       i_rx,
   output logic [7:0] o_byteData,
   output logic       o_byteValid,
   output logic       o_frameErr,
   output logic       o_startDet,
   output logic       o_idle
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(7);

   logic                 r_rxMeta;
   logic                 r_rxSync;
   rxState_t             r_state;
   rxState_t             w_stateNext;
   logic [CNT_W-1:0]     r_clkCnt;
   logic [CNT_W-1:0]     w_clkCntNext;
   logic [BIT_IDX_W-1:0] r_bitIdx;
   logic [BIT_IDX_W-1:0] w_bitIdxNext;
   logic [7:0]           r_shift;
   logic [7:0]           w_shiftNext;
   logic [7:0]           r_byteData;
   logic [7:0]           w_byteDataNext;
   logic                 r_byteValid;
   logic                 w_byteValidNext;
   logic                 r_frameErr;
   logic                 w_frameErrNext;
   logic                 r_parityErr;
   logic                 w_parityErrNext;
   logic                 w_tick;

   // The synchroniser ignores ena so the line is never seen stale when ena returns.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_rxMeta <= 1'b1;
         r_rxSync <= 1'b1;
      end else begin
         r_rxMeta <= i_rx;
         r_rxSync <= r_rxMeta;
      end
   end

   assign w_tick = (r_clkCnt == LAST_CNT);

   always_comb begin
      w_stateNext     = r_state;
      w_clkCntNext    = r_clkCnt;
      w_bitIdxNext    = r_bitIdx;
      w_shiftNext     = r_shift;
      w_byteDataNext  = r_byteData;
      w_byteValidNext = 1'b0;
      w_frameErrNext  = 1'b0;
      w_parityErrNext = r_parityErr;
      case (r_state)
         IDLE: begin
            if (!r_rxSync) begin
               w_stateNext     = START;
               w_clkCntNext    = '0;
               w_bitIdxNext    = '0;
               w_parityErrNext = 1'b0;
            end
         end
         START: begin
            if (r_clkCnt == HALF_CNT) begin
               w_clkCntNext = '0;
               w_stateNext  = r_rxSync ? IDLE : DATA;
            end else begin
               w_clkCntNext = r_clkCnt + 1'b1;
            end
         end
         DATA: begin
            if (w_tick) begin
               w_clkCntNext = '0;
               w_shiftNext  = {r_rxSync, r_shift[7:1]};
               w_bitIdxNext = r_bitIdx + 1'b1;
               if (r_bitIdx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                  w_stateNext = PARITY;
`else
                  w_stateNext = STOP;
`endif
               end
            end else begin
               w_clkCntNext = r_clkCnt + 1'b1;
            end
         end
`ifdef UART_RX_PARITY_EN
         // Even parity: data bits xor parity bit must be zero.
         PARITY: begin
            if (w_tick) begin
               w_clkCntNext    = '0;
               w_parityErrNext = r_rxSync ^ (^r_shift);
               w_stateNext     = STOP;
            end else begin
               w_clkCntNext = r_clkCnt + 1'b1;
            end
         end
`endif
         // Leave mid-stop-bit so a back-to-back start edge is not missed.
         STOP: begin
            if (w_tick) begin
               w_clkCntNext = '0;
               w_stateNext  = IDLE;
               if (r_rxSync && !r_parityErr) begin
                  w_byteValidNext = 1'b1;
                  w_byteDataNext  = r_shift;
               end else begin
                  w_frameErrNext = 1'b1;
               end
            end else begin
               w_clkCntNext = r_clkCnt + 1'b1;
            end
         end
         default: begin
            w_stateNext  = IDLE;
            w_clkCntNext = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state     <= IDLE;
         r_clkCnt    <= '0;
         r_bitIdx    <= '0;
         r_shift     <= '0;
         r_byteData  <= '0;
         r_byteValid <= 1'b0;
         r_frameErr  <= 1'b0;
         r_parityErr <= 1'b0;
      end else if (i_ena) begin
         r_state     <= w_stateNext;
         r_clkCnt    <= w_clkCntNext;
         r_bitIdx    <= w_bitIdxNext;
         r_shift     <= w_shiftNext;
         r_byteData  <= w_byteDataNext;
         r_byteValid <= w_byteValidNext;
         r_frameErr  <= w_frameErrNext;
         r_parityErr <= w_parityErrNext;
      end else begin
         r_byteValid <= 1'b0;
         r_frameErr  <= 1'b0;
      end
   end

   assign o_byteData  = r_byteData;
   assign o_byteValid = r_byteValid;
   assign o_frameErr  = r_frameErr;
   assign o_startDet  = i_ena && (r_state == IDLE) && !r_rxSync;
   assign o_idle      = (r_state == IDLE);

endmodule

// File: rtl/uart_cmd_rx.sv
// UART command receiver: two bytes form one command offered over valid/ready.
// Define UART_RX_PARITY_EN for 8E1 framing (handled inside uart_rx_byte).
module uart_cmd_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 87,
   parameter int TIMEOUT_BITS = 20
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       rx,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   output logic       frame_err,
   output logic [3:0] cmd_a,
   output logic [3:0] cmd_b,
   output logic [2:0] cmd_opcode,
   output logic       cmd_mode,
   output logic       cmd_valid,
   input  logic       cmd_ready,
   output logic       cmd_err,
   output logic       overrun
);

   localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int TO_W     = $clog2(TO_LIMIT + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LIMIT - 1);

   logic [7:0]      w_byteData;
   logic            w_byteValid;
   logic            w_frameErr;
   logic            w_startDet;
   logic            w_idle;

   logic            r_phase;
   logic            w_phaseNext;
   logic [3:0]      r_byte0A;
   logic [3:0]      w_byte0ANext;
   logic [3:0]      r_byte0B;
   logic [3:0]      w_byte0BNext;
   logic [TO_W-1:0] r_toCnt;
   logic [TO_W-1:0] w_toCntNext;
   logic [3:0]      r_cmdA;
   logic [3:0]      w_cmdANext;
   logic [3:0]      r_cmdB;
   logic [3:0]      w_cmdBNext;
   logic [2:0]      r_cmdOpc;
   logic [2:0]      w_cmdOpcNext;
   logic            r_cmdMode;
   logic            w_cmdModeNext;
   logic            r_cmdValid;
   logic            w_cmdValidNext;
   logic            r_cmdErr;
   logic            w_cmdErrNext;
   logic            r_overrun;
   logic            w_overrunNext;

   uart_rx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rxByte (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_ena       (ena),
      .i_rx        (rx),
      .o_byteData  (w_byteData),
      .o_byteValid (w_byteValid),
      .o_frameErr  (w_frameErr),
      .o_startDet  (w_startDet),
      .o_idle      (w_idle)
   );

   // The timeout only counts idle line time while waiting for byte 1.
   always_comb begin
      w_phaseNext    = r_phase;
      w_byte0ANext   = r_byte0A;
      w_byte0BNext   = r_byte0B;
      w_toCntNext    = r_toCnt;
      w_cmdANext     = r_cmdA;
      w_cmdBNext     = r_cmdB;
      w_cmdOpcNext   = r_cmdOpc;
      w_cmdModeNext  = r_cmdMode;
      w_cmdValidNext = r_cmdValid;
      w_cmdErrNext   = 1'b0;
      w_overrunNext  = 1'b0;

      if (r_cmdValid && cmd_ready) begin
         w_cmdValidNext = 1'b0;
      end

      if (w_frameErr) begin
         w_phaseNext = 1'b0;
         w_toCntNext = '0;
      end else if (w_byteValid) begin
         if (!r_phase) begin
            w_phaseNext  = 1'b1;
            w_byte0ANext = w_byteData[A_MSB:A_LSB];
            w_byte0BNext = w_byteData[B_MSB:B_LSB];
            w_toCntNext  = '0;
         end else begin
            w_phaseNext = 1'b0;
            w_toCntNext = '0;
            if (!sigOk(w_byteData)) begin
               w_cmdErrNext = 1'b1;
            end else if (!r_cmdValid || cmd_ready) begin
               w_cmdANext     = r_byte0A;
               w_cmdBNext     = r_byte0B;
               w_cmdOpcNext   = w_byteData[OPC_MSB:OPC_LSB];
               w_cmdModeNext  = w_byteData[MODE_POS];
               w_cmdValidNext = 1'b1;
            end else begin
               w_overrunNext = 1'b1;
            end
         end
      end else if (r_phase) begin
         if (w_startDet) begin
            w_toCntNext = '0;
         end else if (w_idle) begin
            if (r_toCnt == TO_LAST) begin
               w_cmdErrNext = 1'b1;
               w_phaseNext  = 1'b0;
               w_toCntNext  = '0;
            end else begin
               w_toCntNext = r_toCnt + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_phase    <= 1'b0;
         r_byte0A   <= '0;
         r_byte0B   <= '0;
         r_toCnt    <= '0;
         r_cmdA     <= '0;
         r_cmdB     <= '0;
         r_cmdOpc   <= '0;
         r_cmdMode  <= 1'b0;
         r_cmdValid <= 1'b0;
         r_cmdErr   <= 1'b0;
         r_overrun  <= 1'b0;
      end else if (ena) begin
         r_phase    <= w_phaseNext;
         r_byte0A   <= w_byte0ANext;
         r_byte0B   <= w_byte0BNext;
         r_toCnt    <= w_toCntNext;
         r_cmdA     <= w_cmdANext;
         r_cmdB     <= w_cmdBNext;
         r_cmdOpc   <= w_cmdOpcNext;
         r_cmdMode  <= w_cmdModeNext;
         r_cmdValid <= w_cmdValidNext;
         r_cmdErr   <= w_cmdErrNext;
         r_overrun  <= w_overrunNext;
      end else begin
         r_cmdErr  <= 1'b0;
         r_overrun <= 1'b0;
      end
   end

   assign byte_data  = w_byteData;
   assign byte_valid = w_byteValid;
   assign frame_err  = w_frameErr;
   assign cmd_a      = r_cmdA;
   assign cmd_b      = r_cmdB;
   assign cmd_opcode = r_cmdOpc;
   assign cmd_mode   = r_cmdMode;
   assign cmd_valid  = r_cmdValid;
   assign cmd_err    = r_cmdErr;
   assign overrun    = r_overrun;

endmodule
